// File: rtl/button_conditioner.sv
// Five-lane push-button front end: 2-flop sync, debounce, press/release pulses
// and hold-to-repeat step pulses on the lanes selected by REPEAT_MASK.
module button_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         REPEAT_DELAY    = 25000000,
  parameter int         REPEAT_PERIOD   = 5000000,
  parameter logic [4:0] REPEAT_MASK     = 5'b00011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release,
  output logic [4:0] btn_step
);

  localparam int NB   = 5;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_e;

  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] level_q, level_d;
  logic [NB-1:0] press_q, press_d;
  logic [NB-1:0] release_q, release_d;
  logic [NB-1:0] step_q, step_d;
  logic [DW-1:0] db_cnt_q  [NB];
  logic [DW-1:0] db_cnt_d  [NB];
  logic [RW-1:0] rpt_cnt_q [NB];
  logic [RW-1:0] rpt_cnt_d [NB];
  rpt_state_e    state_q   [NB];
  rpt_state_e    state_d   [NB];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      step_q    <= '0;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i]  <= '0;
        rpt_cnt_q[i] <= '0;
        state_q[i]   <= ST_IDLE;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      step_q    <= step_d;
      for (int i = 0; i < NB; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
        state_q[i]   <= state_d[i];
      end
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    step_d    = '0;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i]  = '0;
      rpt_cnt_d[i] = '0;
      state_d[i]   = state_q[i];

      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i]   = ~level_q[i];
          press_d[i]   = ~level_q[i];
          release_d[i] = level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      if (REPEAT_MASK[i]) begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (press_d[i]) state_d[i] = ST_DELAY;
          end
          ST_DELAY: begin
            if (rpt_cnt_q[i] == DELAY_LAST) begin
              step_d[i]  = 1'b1;
              state_d[i] = ST_REPEAT;
            end else begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[i] == PERIOD_LAST) step_d[i] = 1'b1;
            else rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
          end
          default: state_d[i] = ST_IDLE;
        endcase
        // A release landing on a repeat-due cycle suppresses that step.
        if (release_d[i]) begin
          state_d[i]   = ST_IDLE;
          rpt_cnt_d[i] = '0;
          step_d[i]    = 1'b0;
        end
      end

      step_d[i] = step_d[i] | press_d[i];
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_step    = step_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// all checked against a sample-window / time-since-press reference model.
module tb_button_conditioner;

  localparam int         D    = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [4:0] MASK = 5'b00011;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic [4:0] btn_level, btn_press, btn_release, btn_step;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_step   (btn_step)
  );

  always #5 clk = ~clk;

  // Reference model: a level flips once the last D synchronised samples all
  // disagree with it; steps are derived from the time elapsed since the press.
  logic [4:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  logic [4:0] m_press = '0, m_rel = '0, m_step = '0;
  bit         m_hist [5][$];
  int         m_pt   [5];
  int         m_cyc = 0;

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_press = '0; m_rel = '0; m_step = '0;
      for (int i = 0; i < 5; i++) m_hist[i].delete();
    end else begin
      m_press = '0; m_rel = '0; m_step = '0;
      for (int i = 0; i < 5; i++) begin
        bit all_diff;
        m_hist[i].push_back(m_s2[i]);
        if (m_hist[i].size() > D) void'(m_hist[i].pop_front());
        all_diff = (m_hist[i].size() == D);
        foreach (m_hist[i][j]) if (m_hist[i][j] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) begin
            m_press[i] = 1'b1;
            m_pt[i]    = m_cyc;
          end else begin
            m_rel[i] = 1'b1;
          end
          m_hist[i].delete();
        end
        if (m_press[i]) m_step[i] = 1'b1;
        else if (MASK[i] && m_lvl[i] && (m_cyc - m_pt[i]) >= RD &&
                 ((m_cyc - m_pt[i] - RD) % RP) == 0)
          m_step[i] = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  end

  task automatic test_reset();
    reset   = 1'b1;
    btn_raw = 5'h15;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_step} !== 20'h0) begin
        n_err++;
        $display("FAIL reset_outputs k=%0d got %h want 0", k,
                 {btn_level, btn_press, btn_release, btn_step});
      end
    end
    btn_raw = '0;
    reset   = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_clean_press();
    reset = 1'b1; btn_raw = '0;
    @(negedge clk);
    reset = 1'b0; btn_raw = 5'b00100;
    for (int k = 0; k < 30; k++) begin
      logic [19:0] want;
      @(negedge clk);
      want = {(k >= 5) ? 5'b00100 : 5'b0, (k == 5) ? 5'b00100 : 5'b0,
              5'b0, (k == 5) ? 5'b00100 : 5'b0};
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_step} !== want) begin
        n_err++;
        $display("FAIL clean_press k=%0d got %h want %h", k,
                 {btn_level, btn_press, btn_release, btn_step}, want);
      end
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_step} !== {m_lvl, m_press, m_rel, m_step}) begin
        n_err++;
        $display("FAIL clean_press_model k=%0d got %h want %h", k,
                 {btn_level, btn_press, btn_release, btn_step}, {m_lvl, m_press, m_rel, m_step});
      end
    end
    btn_raw = '0;
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    pat = 16'b0000_0000_0111_0111;
    reset = 1'b1; btn_raw = '0;
    @(negedge clk);
    reset = 1'b0; btn_raw = {4'b0, pat[0]};
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_step} !== 20'h0) begin
        n_err++;
        $display("FAIL bounce k=%0d got %h want 0", k,
                 {btn_level, btn_press, btn_release, btn_step});
      end
      btn_raw = {4'b0, (k + 1 < 16) ? pat[k+1] : 1'b0};
    end
  endtask

  // Hold up for h cycles; press lands on edge 5, release on edge h+5.
  task automatic test_hold(input int h);
    int rel;
    rel = h + 5;
    reset = 1'b1; btn_raw = '0;
    @(negedge clk);
    reset = 1'b0; btn_raw = 5'b00001;
    for (int k = 0; k < rel + 20; k++) begin
      logic want_step, want_rel;
      @(negedge clk);
      want_step = (k == 5) || (k >= 15 && k < rel && ((k - 15) % RP) == 0);
      want_rel  = (k == rel);
      n_cmp++;
      if (btn_step[0] !== want_step || btn_release[0] !== want_rel) begin
        n_err++;
        $display("FAIL hold%0d k=%0d got step=%b rel=%b want step=%b rel=%b",
                 h, k, btn_step[0], btn_release[0], want_step, want_rel);
      end
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_step} !== {m_lvl, m_press, m_rel, m_step}) begin
        n_err++;
        $display("FAIL hold%0d_model k=%0d got %h want %h", h, k,
                 {btn_level, btn_press, btn_release, btn_step}, {m_lvl, m_press, m_rel, m_step});
      end
      if (k == h - 1) btn_raw = '0;
    end
  endtask

  task automatic test_reset_in_delay();
    reset = 1'b1; btn_raw = '0;
    @(negedge clk);
    reset = 1'b0; btn_raw = 5'b00010;
    for (int k = 0; k < 35; k++) begin
      logic want_press, want_step;
      @(negedge clk);
      if (k == 9) begin
        n_cmp++;
        if ({btn_level, btn_press, btn_release, btn_step} !== 20'h0) begin
          n_err++;
          $display("FAIL reset_in_delay_clear got %h want 0",
                   {btn_level, btn_press, btn_release, btn_step});
        end
      end
      want_press = (k == 5) || (k == 15);
      want_step  = want_press || (k == 25) || (k == 28) || (k == 31) || (k == 34);
      n_cmp++;
      if (btn_press[1] !== want_press || btn_step[1] !== want_step) begin
        n_err++;
        $display("FAIL reset_in_delay k=%0d got press=%b step=%b want press=%b step=%b",
                 k, btn_press[1], btn_step[1], want_press, want_step);
      end
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_step} !== {m_lvl, m_press, m_rel, m_step}) begin
        n_err++;
        $display("FAIL reset_in_delay_model k=%0d got %h want %h", k,
                 {btn_level, btn_press, btn_release, btn_step}, {m_lvl, m_press, m_rel, m_step});
      end
      reset = (k == 8);
    end
    btn_raw = '0;
  endtask

  task automatic test_simultaneous();
    reset = 1'b1; btn_raw = '0;
    @(negedge clk);
    reset = 1'b0; btn_raw = 5'h1f;
    for (int k = 0; k < 40; k++) begin
      logic [4:0] want_press, want_rel, want_step;
      @(negedge clk);
      want_press = (k == 5) ? 5'h1f : 5'h0;
      want_rel   = (k == 25) ? 5'h1f : 5'h0;
      want_step  = want_press | (((k == 15) || (k == 18) || (k == 21) || (k == 24)) ? MASK : 5'h0);
      n_cmp++;
      if (btn_press !== want_press || btn_release !== want_rel || btn_step !== want_step) begin
        n_err++;
        $display("FAIL simultaneous k=%0d got p=%h r=%h s=%h want p=%h r=%h s=%h",
                 k, btn_press, btn_release, btn_step, want_press, want_rel, want_step);
      end
      if (k == 19) btn_raw = '0;
    end
  endtask

  task automatic test_random();
    int dur [5];
    reset = 1'b1; btn_raw = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) dur[i] = $urandom_range(1, 40);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({btn_level, btn_press, btn_release, btn_step} !== {m_lvl, m_press, m_rel, m_step}) begin
        n_err++;
        $display("FAIL random k=%0d got %h want %h", k,
                 {btn_level, btn_press, btn_release, btn_step}, {m_lvl, m_press, m_rel, m_step});
      end
      for (int i = 0; i < 5; i++) begin
        dur[i]--;
        if (dur[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 45);
        end
      end
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold(40);
    test_hold(41);
    test_reset_in_delay();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
